mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port SRAM between the instruction-fetch port (IF) and the data
//  port (DM) of the CPU. DM is driven by the decoder's mem_cs/mem_we/mem_oe signals.
//  Runs a small FSM that serialises accesses, handles the SRAM read latency and
//  returns read data. It also generates the pipeline stall while an access is pending.
// PARAMETERS
//  ADDR_W  14  SRAM word-address width
//  DATA_W  32  data width (4 byte lanes; fixed at 32)
//  RD_LAT  1   SRAM read latency in cycles, legal range 1..4
// PORTS
//  clk         in   1       clock; all state updates on the rising edge
//  rst         in   1       synchronous reset, active-high
//  if_req      in   1       fetch request; held until if_gnt
//  if_addr     in   ADDR_W  fetch word address
//  if_gnt      out  1       1-cycle pulse: fetch complete, if_rdata valid
//  if_rdata    out  DATA_W  fetched instruction (registered)
//  dm_cs       in   1       data request; held until dm_done
//  dm_we       in   4       byte write enables, active-low (1111 = read, 0000 = SW)
//  dm_oe       in   1       read output enable
//  dm_addr     in   ADDR_W  data word address
//  dm_wdata    in   DATA_W  store data, already lane-aligned
//  dm_done     out  1       1-cycle pulse: data access complete
//  dm_rdata    out  DATA_W  load data (registered), valid with dm_done
//  stall       out  1       (if_req & ~if_gnt) | (dm_cs & ~dm_done), combinational
//  sram_cs     out  1       SRAM chip select
//  sram_oe     out  1       SRAM output enable
//  sram_web    out  4       SRAM byte write enables, active-low
//  sram_a      out  ADDR_W  SRAM address
//  sram_di     out  DATA_W  SRAM write data
//  sram_do     in   DATA_W  SRAM read data
// BEHAVIOUR
//  - Reset values:
//    - state = IDLE; sram_cs = 0, sram_oe = 0, sram_web = 1111, sram_a = 0, sram_di = 0.
//    - if_gnt = 0, dm_done = 0, if_rdata = 0, dm_rdata = 0, owner = IF.
//    - Reset mid-access aborts the access with no done pulse.
//  - FSM states: IDLE -> ACCESS -> RESP -> IDLE.
//  - Requests are sampled only in IDLE.
//  - Priority: dm_cs wins over if_req, because the MEM-stage op is older. A running
//    access is never preempted.
//  - Grant in IDLE at cycle N:
//    - The arbiter registers owner, addr, we, wdata.
//    - The SRAM outputs are driven from cycle N+1.
//  - Read (IF, or DM with dm_oe = 1 and dm_we = 1111):
//    - sram_cs = sram_oe = 1 and sram_web = 1111 for RD_LAT cycles (N+1..N+RD_LAT).
//    - sram_do is captured at the end of cycle N+RD_LAT.
//    - The done pulse plus rdata appear in RESP = cycle N+RD_LAT+1.
//  - Write (dm_we != 1111):
//    - sram_cs = 1, sram_oe = 0, sram_web = dm_we, sram_di = dm_wdata for 1 cycle,
//      independent of RD_LAT.
//    - dm_done is asserted in cycle N+2.
//  - DM no-op (dm_cs = 1, dm_we = 1111, dm_oe = 0): 1 ACCESS cycle with sram_cs = 0,
//    then dm_done.
//  - ACCESS latency counter: width $clog2(RD_LAT+1). Loaded at grant, decrements to 0,
//    leaves ACCESS at 0.
//  - RESP lasts exactly 1 cycle and accepts no request. A request still high in the
//    done cycle is therefore never re-issued; the requester updates it in that cycle.
//  - rdata of the non-owner port holds its previous value.
//  - Only one of if_gnt / dm_done is high in a given cycle.
//  - Outside ACCESS: sram_cs = 0, sram_oe = 0, sram_web = 1111. sram_a and sram_di
//    hold their last value.
//  - A request dropped mid-access still completes; its done pulse is ignored by the
//    requester.
//  - Worst-case wait for IF behind DM: 2 + RD_LAT cycles.
// STRUCTURE
//  - Package mem_arb_pkg holds:
//    - typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t
//    - typedef enum logic {OWN_IF, OWN_DM} arb_owner_t
//    - localparam WE_READ = 4'b1111
//  - Single module; no sub-module. The latency counter and FSM are inline, SRAM-side
//    outputs are registered, stall is combinational.
// TESTING
//  1. IF read, RD_LAT = 2:
//     - Stimulus: if_req = 1, if_addr = 0x0010 at N; sram_do = 0xDEADBEEF.
//     - Response: sram_cs/oe = 1 in N+1..N+2, sram_a = 0x0010; if_gnt = 1 at N+3 with
//       if_rdata = 0xDEADBEEF; stall = 1 through N+2.
//  2. SW:
//     - Stimulus: dm_cs = 1, dm_we = 0000, dm_addr = 0x0020, dm_wdata = 0x12345678.
//     - Response: one cycle of sram_web = 0000, sram_di = 0x12345678; dm_done at N+2.
//  3. SB lane 0:
//     - Stimulus: dm_we = 1110.
//     - Response: sram_web = 1110 for exactly 1 cycle, then 1111.
//  4. Simultaneous requests:
//     - Stimulus: if_req and LW (dm_oe = 1) both high at N.
//     - Response: the DM access is served first (dm_done at N+RD_LAT+1); the IF grant
//       starts in the following IDLE; no overlap of sram_cs.
//  5. Held request:
//     - Stimulus: if_req stays high after if_gnt.
//     - Response: exactly one new access per IDLE, no duplicate done inside RESP.
//  6. Reset mid-access:
//     - Stimulus: rst = 1 in ACCESS.
//     - Response: next cycle state = IDLE, sram_cs = 0, sram_web = 1111, no
//       if_gnt/dm_done.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port SRAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_DM} arb_owner_t;

  localparam logic [3:0] WE_READ = 4'b1111;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port SRAM between instruction fetch (IF) and data memory (DM).
// Serialises accesses through IDLE -> ACCESS -> RESP and returns registered read data.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_cs,
  input  logic [3:0]        dm_we,
  input  logic              dm_oe,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              stall,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic [3:0]        sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_di,
  input  logic [DATA_W-1:0] sram_do
);

  localparam int unsigned CntW = $clog2(RD_LAT + 1);

  arb_state_t      state_q;
  arb_owner_t      owner_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      cnt_q    <= '0;
      sram_cs  <= 1'b0;
      sram_oe  <= 1'b0;
      sram_web <= WE_READ;
      sram_a   <= '0;
      sram_di  <= '0;
      if_gnt   <= 1'b0;
      dm_done  <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if_gnt  <= 1'b0;
      dm_done <= 1'b0;
      case (state_q)
        IDLE: begin
          // DM wins: the MEM-stage operation is older than the fetch.
          if (dm_cs) begin
            state_q <= ACCESS;
            owner_q <= OWN_DM;
            sram_a  <= dm_addr;
            if (dm_we != WE_READ) begin
              sram_cs  <= 1'b1;
              sram_web <= dm_we;
              sram_di  <= dm_wdata;
              cnt_q    <= '0;
            end else if (dm_oe) begin
              sram_cs <= 1'b1;
              sram_oe <= 1'b1;
              cnt_q   <= CntW'(RD_LAT - 1);
            end else begin
              cnt_q <= '0;
            end
          end else if (if_req) begin
            state_q <= ACCESS;
            owner_q <= OWN_IF;
            sram_a  <= if_addr;
            sram_cs <= 1'b1;
            sram_oe <= 1'b1;
            cnt_q   <= CntW'(RD_LAT - 1);
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            state_q  <= RESP;
            sram_cs  <= 1'b0;
            sram_oe  <= 1'b0;
            sram_web <= WE_READ;
            if (owner_q == OWN_IF) begin
              if_gnt   <= 1'b1;
              if_rdata <= sram_do;
            end else begin
              dm_done <= 1'b1;
              if (sram_oe) begin
                dm_rdata <= sram_do;
              end
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall = (if_req & ~if_gnt) | (dm_cs & ~dm_done);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level expectation model plus directed checks.
module tb_mem_arbiter;

  localparam int unsigned RdLat = 2;
  localparam int MaxC = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [13:0] if_addr;
  logic        if_gnt;
  logic [31:0] if_rdata;
  logic        dm_cs;
  logic [3:0]  dm_we;
  logic        dm_oe;
  logic [13:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_done;
  logic [31:0] dm_rdata;
  logic        stall;
  logic        sram_cs;
  logic        sram_oe;
  logic [3:0]  sram_web;
  logic [13:0] sram_a;
  logic [31:0] sram_di;
  logic [31:0] sram_do;

  mem_arbiter #(.ADDR_W(14), .DATA_W(32), .RD_LAT(RdLat)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata),
    .dm_cs(dm_cs), .dm_we(dm_we), .dm_oe(dm_oe), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .stall(stall),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web), .sram_a(sram_a),
    .sram_di(sram_di), .sram_do(sram_do)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Expected outputs per cycle, filled in ahead of time when an access is granted.
  logic        e_cs[MaxC], e_oe[MaxC], e_gnt[MaxC], e_done[MaxC];
  logic [3:0]  e_web[MaxC];
  logic [13:0] e_a[MaxC];
  logic [31:0] e_di[MaxC], e_ifr[MaxC], e_dmr[MaxC];
  bit model_on = 0;
  int free_at = 0;
  int cap_cyc = -1;
  bit cap_dm = 0;

  initial begin
    for (int c = 0; c < MaxC; c++) begin
      e_cs[c] = 0; e_oe[c] = 0; e_gnt[c] = 0; e_done[c] = 0; e_web[c] = 4'hF;
      e_a[c] = '0; e_di[c] = '0; e_ifr[c] = '0; e_dmr[c] = '0;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      automatic int k = cyc;
      automatic int lat;
      automatic bit rd;
      chk("sram_cs", 32'(sram_cs), 32'(e_cs[k]));
      chk("sram_oe", 32'(sram_oe), 32'(e_oe[k]));
      chk("sram_web", 32'(sram_web), 32'(e_web[k]));
      chk("sram_a", 32'(sram_a), 32'(e_a[k]));
      chk("sram_di", sram_di, e_di[k]);
      chk("if_gnt", 32'(if_gnt), 32'(e_gnt[k]));
      chk("dm_done", 32'(dm_done), 32'(e_done[k]));
      chk("if_rdata", if_rdata, e_ifr[k]);
      chk("dm_rdata", dm_rdata, e_dmr[k]);
      chk("stall", 32'(stall), 32'((if_req & ~e_gnt[k]) | (dm_cs & ~e_done[k])));
      if (rst) begin
        for (int c = k + 1; c < MaxC; c++) begin
          e_cs[c] = 0; e_oe[c] = 0; e_gnt[c] = 0; e_done[c] = 0; e_web[c] = 4'hF;
          e_a[c] = '0; e_di[c] = '0; e_ifr[c] = '0; e_dmr[c] = '0;
        end
        free_at = k + 1;
        cap_cyc = -1;
      end else begin
        if (k == cap_cyc) begin
          for (int c = k + 1; c < MaxC; c++)
            if (cap_dm) e_dmr[c] = sram_do; else e_ifr[c] = sram_do;
        end
        if (k >= free_at && (dm_cs || if_req)) begin
          if (dm_cs) begin
            rd = (dm_we == 4'hF) && dm_oe;
            lat = rd ? int'(RdLat) : 1;
            for (int c = k + 1; c < MaxC; c++) e_a[c] = dm_addr;
            for (int c = k + 1; c <= k + lat; c++) begin
              e_cs[c] = rd || (dm_we != 4'hF);
              e_oe[c] = rd;
              e_web[c] = dm_we;
            end
            if (dm_we != 4'hF)
              for (int c = k + 1; c < MaxC; c++) e_di[c] = dm_wdata;
            e_done[k + lat + 1] = 1;
            cap_dm = 1;
          end else begin
            rd = 1;
            lat = int'(RdLat);
            for (int c = k + 1; c < MaxC; c++) e_a[c] = if_addr;
            for (int c = k + 1; c <= k + lat; c++) begin
              e_cs[c] = 1; e_oe[c] = 1;
            end
            e_gnt[k + lat + 1] = 1;
            cap_dm = 0;
          end
          cap_cyc = rd ? k + lat : -1;
          free_at = k + lat + 2;
        end
      end
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_neg(input int c);
    do @(negedge clk); while (cyc < c);
    #1;
  endtask

  typedef struct {
    bit          use_if;
    bit          use_dm;
    logic [3:0]  we;
    bit          oe;
    logic [13:0] ia;
    logic [13:0] da;
    logic [31:0] wd;
    logic [31:0] dov;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #100000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    int cnt;
    bit ifp, dmp;
    rst = 1; if_req = 0; if_addr = '0; dm_cs = 0; dm_we = 4'hF; dm_oe = 0;
    dm_addr = '0; dm_wdata = '0; sram_do = '0;
    go();
    model_on = 1;
    go();
    rst = 0;
    wait_neg(2);
    chk("rst_cs", 32'(sram_cs), 32'd0);
    chk("rst_web", 32'(sram_web), 32'hF);
    chk("rst_gnt_done", 32'({if_gnt, dm_done}), 32'd0);
    chk("rst_rdata", if_rdata | dm_rdata, 32'd0);

    // IF read
    go(); if_req = 1; if_addr = 14'h0010; sram_do = 32'hDEADBEEF; n = cyc;
    wait_neg(n + 1);
    chk("t1_cs_oe", 32'({sram_cs, sram_oe}), 32'd3);
    chk("t1_a", 32'(sram_a), 32'h10);
    wait_neg(n + 2);
    chk("t1_cs2_stall", 32'({sram_cs, stall}), 32'd3);
    wait_neg(n + 3);
    chk("t1_gnt", 32'(if_gnt), 32'd1);
    chk("t1_rdata", if_rdata, 32'hDEADBEEF);
    go(); if_req = 0;

    // SW
    go(); dm_cs = 1; dm_we = 4'b0000; dm_addr = 14'h0020; dm_wdata = 32'h12345678; n = cyc;
    wait_neg(n + 1);
    chk("t2_web", 32'(sram_web), 32'h0);
    chk("t2_di", sram_di, 32'h12345678);
    wait_neg(n + 2);
    chk("t2_done", 32'(dm_done), 32'd1);
    go(); dm_cs = 0;

    // SB lane 0
    go(); dm_cs = 1; dm_we = 4'b1110; dm_addr = 14'h0021; dm_wdata = 32'h000000AB; n = cyc;
    wait_neg(n + 1);
    chk("t3_web", 32'(sram_web), 32'hE);
    wait_neg(n + 2);
    chk("t3_web_after", 32'(sram_web), 32'hF);
    go(); dm_cs = 0; dm_we = 4'hF;

    // DM no-op
    go(); dm_cs = 1; dm_oe = 0; dm_addr = 14'h0022; n = cyc;
    wait_neg(n + 1);
    chk("noop_cs", 32'(sram_cs), 32'd0);
    wait_neg(n + 2);
    chk("noop_done", 32'(dm_done), 32'd1);
    go(); dm_cs = 0;

    // Simultaneous IF and LW
    go(); if_req = 1; if_addr = 14'h0030; dm_cs = 1; dm_oe = 1; dm_addr = 14'h0040;
    sram_do = 32'hCAFEF00D; n = cyc;
    wait_neg(n + 1);
    chk("t4_a_dm", 32'(sram_a), 32'h40);
    wait_neg(n + 3);
    chk("t4_done", 32'({dm_done, if_gnt}), 32'd2);
    chk("t4_dm_rdata", dm_rdata, 32'hCAFEF00D);
    go(); dm_cs = 0; dm_oe = 0; sram_do = 32'h0BADC0DE;
    wait_neg(n + 5);
    chk("t4_a_if", 32'(sram_a), 32'h30);
    wait_neg(n + 7);
    chk("t4_gnt", 32'(if_gnt), 32'd1);
    chk("t4_if_rdata", if_rdata, 32'h0BADC0DE);
    go(); if_req = 0;

    // Held fetch request: one access per IDLE
    go(); if_req = 1; if_addr = 14'h0050; n = cyc; cnt = 0;
    for (int i = 0; i < 12; i++) begin
      wait_neg(n + i);
      if (if_gnt) cnt++;
    end
    chk("t5_gnt_count", 32'(cnt), 32'd3);
    go(); if_req = 0;

    // Reset in ACCESS
    go(); dm_cs = 1; dm_oe = 1; dm_addr = 14'h0060; n = cyc;
    go(); rst = 1;
    wait_neg(n + 1);
    chk("t6_cs_before", 32'(sram_cs), 32'd1);
    go(); rst = 0; dm_cs = 0; dm_oe = 0;
    wait_neg(n + 2);
    chk("t6_cs_web", 32'({sram_cs, sram_web}), 32'hF);
    chk("t6_rdata", dm_rdata, 32'd0);
    wait_neg(n + 3);
    chk("t6_no_done", 32'({if_gnt, dm_done}), 32'd0);

    vecs[0] = '{1, 0, 4'hF, 0, 14'h0111, 14'h0000, 32'h0, 32'h11111111};
    vecs[1] = '{0, 1, 4'b1100, 0, 14'h0000, 14'h0222, 32'hBEEF0000, 32'h0};
    vecs[2] = '{1, 1, 4'hF, 1, 14'h3FFF, 14'h0333, 32'h0, 32'h55AA55AA};
    vecs[3] = '{1, 1, 4'hF, 0, 14'h0001, 14'h0444, 32'h0, 32'h76543210};
    vecs[4] = '{0, 1, 4'b0111, 0, 14'h0000, 14'h0555, 32'hAB000000, 32'h0};
    foreach (vecs[v]) begin
      go();
      if_req = vecs[v].use_if; if_addr = vecs[v].ia;
      dm_cs = vecs[v].use_dm; dm_we = vecs[v].we; dm_oe = vecs[v].oe;
      dm_addr = vecs[v].da; dm_wdata = vecs[v].wd; sram_do = vecs[v].dov;
      ifp = vecs[v].use_if; dmp = vecs[v].use_dm;
      for (int t = 0; t < 30 && (ifp || dmp); t++) begin
        @(negedge clk); #1;
        if (if_gnt) ifp = 0;
        if (dm_done) dmp = 0;
        go();
        if (!ifp) if_req = 0;
        if (!dmp) begin dm_cs = 0; dm_we = 4'hF; dm_oe = 0; end
      end
      chk("vec_timeout", 32'({ifp, dmp}), 32'd0);
    end

    repeat (4) go();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
